// File: rtl/ccff_chain_loader_pkg.sv
// Shared types, CRC constants and the bit-serial CRC-16-CCITT step for the ccff chain loader.
// VERIFY state exists only when CCFF_LOADER_VERIFY_EN is defined.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef CCFF_LOADER_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_DONE  = 3'd4
  } ldr_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first CRC-16-CCITT step over a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return fb ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) between the configuration front-end and the chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic              bs_valid;
  logic              bs_ready;
  logic [WORD_W-1:0] bs_data;

  modport master (output bs_valid, output bs_data, input bs_ready);
  modport slave  (input bs_valid, input bs_data, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader_crc16.sv
// Bit-serial CRC-16-CCITT register with synchronous clear and per-bit enable.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words onto the ccff chain head, gating prog_clk via chain_clk_en.
// Optional read-back CRC check through the chain tail when CCFF_LOADER_VERIFY_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 2048,
  parameter int WORD_W    = 32
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                abort,
  ccff_chain_loader_if.slave  bs,
  output logic                ccff_head,
  input  logic                ccff_tail,
  output logic                chain_clk_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WBIT_W = $clog2(WORD_W);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WORD_W - 1);
  localparam logic [WBIT_W-1:0] WBIT_ONE  = WBIT_W'(1);

  ldr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WBIT_W-1:0] wbit_q, wbit_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;

`ifdef CCFF_LOADER_VERIFY_EN
  logic        crc_clr;
  logic        crc_ld_en;
  logic        crc_rb_en;
  logic [15:0] crc_ld;
  logic [15:0] crc_rb;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    wbit_d   = wbit_q;
    err_d    = err_q;
    sreg_d   = sreg_q;
`ifdef CCFF_LOADER_VERIFY_EN
    crc_clr   = 1'b0;
    crc_ld_en = 1'b0;
    crc_rb_en = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          bitcnt_d = '0;
          err_d    = 1'b0;
          state_d  = ST_FETCH;
`ifdef CCFF_LOADER_VERIFY_EN
          crc_clr  = 1'b1;
`endif
        end
      end
      ST_FETCH: begin
        if (bs.bs_valid) begin
          sreg_d  = bs.bs_data;
          wbit_d  = WBIT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d   = {sreg_q[WORD_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + CNT_ONE;
        wbit_d   = wbit_q - WBIT_ONE;
`ifdef CCFF_LOADER_VERIFY_EN
        crc_ld_en = 1'b1;
`endif
        // Chain length wins over word boundary: leftover low bits of the last word are dropped.
        if (bitcnt_q == CNT_LAST) begin
`ifdef CCFF_LOADER_VERIFY_EN
          bitcnt_d = '0;
          state_d  = ST_VERIFY;
`else
          state_d  = ST_DONE;
`endif
        end else if (wbit_q == '0) begin
          state_d = ST_FETCH;
        end
      end
`ifdef CCFF_LOADER_VERIFY_EN
      ST_VERIFY: begin
        bitcnt_d  = bitcnt_q + CNT_ONE;
        crc_rb_en = 1'b1;
        // Compare against the read-back CRC including this cycle's tail bit.
        if (bitcnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (crc16_step(crc_rb, ccff_tail) != crc_ld) begin
            err_d = 1'b1;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      wbit_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      wbit_q   <= wbit_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge prog_clk) begin
    sreg_q <= sreg_d;
  end

`ifdef CCFF_LOADER_VERIFY_EN
  ccff_crc16_serial u_crc_ld (
    .clk   (prog_clk),
    .rst_n (prog_rst_n),
    .clr   (crc_clr),
    .en    (crc_ld_en),
    .din   (ccff_head),
    .crc   (crc_ld)
  );

  ccff_crc16_serial u_crc_rb (
    .clk   (prog_clk),
    .rst_n (prog_rst_n),
    .clr   (crc_clr),
    .en    (crc_rb_en),
    .din   (ccff_tail),
    .crc   (crc_rb)
  );

  // Recirculating the tail back into the head keeps the loaded image intact during read-back.
  assign ccff_head    = (state_q == ST_SHIFT)  ? sreg_q[WORD_W-1] :
                        (state_q == ST_VERIFY) ? ccff_tail : 1'b0;
  assign chain_clk_en = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
`else
  assign ccff_head    = (state_q == ST_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
  assign chain_clk_en = (state_q == ST_SHIFT);
`endif

  assign bs.bs_ready = (state_q == ST_FETCH);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;

endmodule
